// File: rtl/sn74ls443_bus.sv
// Quad-bit three-port inverting bus transceiver, open-collector outputs.
// A clocked arm flag gates all drive; the data path is purely combinational.
module sn74ls443_bus (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire  [3:0] a,
  inout  wire  [3:0] b,
  inout  wire  [3:0] c,
  input  logic       cs,
  input  logic       s1,
  input  logic       s0,
  input  logic       ga,
  input  logic       gb,
  input  logic       gc
);

  logic       armed;
  logic       en_a;
  logic       en_b;
  logic       en_c;
  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] src_c;
  logic [3:0] drv_a;
  logic [3:0] drv_b;
  logic [3:0] drv_c;

  always_ff @(posedge clk) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // A known 0 term dominates, so an x control only reaches ports it could enable
  assign en_a = armed & ~cs & ~ga & (s1 ^ s0);
  assign en_b = armed & ~cs & ~gb & ~s0;
  assign en_c = armed & ~cs & ~gc & ~s1;

  // Each port's source never includes itself
  assign src_a = s1 ? c : b;
  assign src_b = s1 ? c : a;
  assign src_c = s0 ? b : a;

  assign drv_a = {4{en_a}} & src_a;
  assign drv_b = {4{en_b}} & src_b;
  assign drv_c = {4{en_c}} & src_c;

  // Pull low for a source 1, float otherwise; an unknown term yields x
  for (genvar i = 0; i < 4; i++) begin : g_oc
    assign a[i] = drv_a[i] ? 1'b0 : 1'bz;
    assign b[i] = drv_b[i] ? 1'b0 : 1'bz;
    assign c[i] = drv_c[i] ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_sn74ls443_bus.sv
// Bench for sn74ls443_bus: board pull-ups turn released bits into 1,
// so expectations are the pulled-up bus levels.
module tb_sn74ls443_bus;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       s1;
  logic       s0;
  logic       ga;
  logic       gb;
  logic       gc;
  logic [3:0] av;
  logic [3:0] bv;
  logic [3:0] cv;
  logic       ao;
  logic       bo;
  logic       co;
  wire  [3:0] a;
  wire  [3:0] b;
  wire  [3:0] c;

  int n_cmp;
  int n_bad;

  assign a = ao ? av : 4'bzzzz;
  assign b = bo ? bv : 4'bzzzz;
  assign c = co ? cv : 4'bzzzz;

  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup (a[i]);
    pullup (b[i]);
    pullup (c[i]);
  end

  sn74ls443_bus dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .cs   (cs),
    .s1   (s1),
    .s0   (s0),
    .ga   (ga),
    .gb   (gb),
    .gc   (gc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic [1:0] s;
    logic [2:0] g;
    logic [3:0] v;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] ec;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Source port (A for s=11) is driven by the bench with v
  task automatic apply(input logic c_n, input logic [1:0] s,
                       input logic [2:0] g, input logic [3:0] v);
    cs = c_n;
    {s1, s0} = s;
    {ga, gb, gc} = g;
    av = v;
    bv = v;
    cv = v;
    ao = (s == 2'b00) || (s == 2'b11);
    bo = (s == 2'b01);
    co = (s == 2'b10);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    apply(1'b0, 2'b00, 3'b100, 4'b0001);

    vt[0]  = '{1'b1, 2'b00, 3'b000, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    vt[1]  = '{1'b0, 2'b11, 3'b000, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    vt[2]  = '{1'b0, 2'b00, 3'b111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    vt[3]  = '{1'b0, 2'b01, 3'b010, 4'b0010, 4'b1101, 4'b0010, 4'b1101};
    vt[4]  = '{1'b0, 2'b10, 3'b001, 4'b0100, 4'b1011, 4'b1011, 4'b0100};
    vt[5]  = '{1'b0, 2'b00, 3'b101, 4'b0001, 4'b0001, 4'b1110, 4'b1111};
    vt[6]  = '{1'b0, 2'b00, 3'b110, 4'b1001, 4'b1001, 4'b1111, 4'b0110};
    vt[7]  = '{1'b0, 2'b00, 3'b000, 4'b1010, 4'b1010, 4'b0101, 4'b0101};
    vt[8]  = '{1'b0, 2'b00, 3'bx11, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    vt[9]  = '{1'b0, 2'b01, 3'b1x1, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    vt[10] = '{1'b0, 2'b10, 3'b11x, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    vt[11] = '{1'b0, 2'b01, 3'b000, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
    vt[12] = '{1'b0, 2'b10, 3'b000, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
    vt[13] = '{1'b0, 2'b00, 3'b011, 4'b1111, 4'b1111, 4'b1111, 4'b1111};

    // Held in reset: nothing driven
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", a, 4'b0001);
    chk("rst_b", b, 4'b1111);
    chk("rst_c", c, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arm_b", b, 4'b1110);
    chk("arm_c", c, 4'b1110);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(vt[i].cs, vt[i].s, vt[i].g, vt[i].v);
      #1;
      chk($sformatf("v%0d_a", i), a, vt[i].ea);
      chk($sformatf("v%0d_b", i), b, vt[i].eb);
      chk($sformatf("v%0d_c", i), c, vt[i].ec);
    end

    // Mid-operation reset releases at the next edge, resumes one edge later
    @(negedge clk);
    apply(1'b0, 2'b00, 3'b000, 4'b0101);
    #1;
    chk("run_b", b, 4'b1010);
    rst_n = 1'b0;
    #1;
    chk("pre_b", b, 4'b1010);
    @(posedge clk);
    #1;
    chk("rel_b", b, 4'b1111);
    chk("rel_c", c, 4'b1111);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wait_b", b, 4'b1111);
    @(posedge clk);
    #1;
    chk("res_b", b, 4'b1010);
    chk("res_c", c, 4'b1010);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sn74ls443_bus.md
SN74LS443_BUS -- requirements
Module: sn74ls443

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock; samples only the reset/arm logic.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 a  inout  4  port A; source when selected, else open-collector output.
REQ-005 b  inout  4  port B; same role as A.
REQ-006 c  inout  4  port C; same role as A.
REQ-007 cs  input  1  chip select, active low; 1 releases all ports.
REQ-008 s1, s0  input  1 each  source select: 00=A, 01=B, 10=C, 11=no source.
REQ-009 ga, gb, gc  input  1 each  per-port output enable, active low.
REQ-010 No parameters; bus width is fixed at 4.

Function
REQ-011 An internal arm flag SHALL clear on any rising clk with rst_n=0 and set on any rising clk with rst_n=1.
REQ-012 While the arm flag is clear, all three ports SHALL be high-impedance regardless of other inputs.
REQ-013 While armed, port X (A/B/C) SHALL be driven only when cs=0, s1s0 selects a source other than X, and gX=0.
REQ-014 The selected source port SHALL never be driven, regardless of its own G input.
REQ-015 s1s0=11 SHALL release all ports.
REQ-016 Output data SHALL be the bitwise inverse of the source port.
REQ-017 Each output bit SHALL be open-collector: drive 0 where the source bit is 1; drive z where the source bit is 0.
REQ-018 A source bit of x or z SHALL produce x on the corresponding driven output bit.
REQ-019 When armed, the data and enable path SHALL be combinational from cs, s1, s0, g* and the source port, with no clock latency.
REQ-020 An x on cs, s1, s0, or a relevant gX SHALL put x on every output bit that could otherwise be driven. Outputs already released by a known control value SHALL stay z.
REQ-021 Destinations SHALL be independent: zero, one, or both non-source ports may be driven at the same time.
REQ-022 The block SHALL contain no pull-ups; external pull-ups are the board's job.

Reset
REQ-023 The arm flag SHALL power up clear, so all ports are z until the first rising clk with rst_n=1.
REQ-024 Asserting rst_n=0 mid-operation SHALL release all ports starting at the next rising clk.
REQ-025 Deasserting rst_n SHALL re-enable driving from the next rising clk; no other state is retained.

Verification
REQ-026 rst_n=0 for 2 clks, cs=0, s=00, ga=1, gb=0, gc=0, a=0001 -> a, b and c all read zzzz. After one clk with rst_n=1 -> b=zzz0 and c=zzz0.
REQ-027 Armed, with either cs=1, s=11 or g=111, all ports undriven -> a, b and c all read zzzz.
REQ-028 Armed, cs=0, s=01, ga=0, gb=1, gc=0, b=0010 -> a=zz0z and c=zz0z. Then s=10, ga=0, gb=0, gc=1, c=0100 -> a=z0zz and b=z0zz.
REQ-029 Armed, cs=0, s=00:
- g=101, a=0001 -> b=zzz0, c=zzzz.
- g=110, a=1001 -> c=0zz0, b=zzzz.
REQ-030 Armed, cs=0, s=00, g=x11 -> no drive. Armed, s=01, g=1x1 -> no drive. Armed, s=10, g=11x -> no drive.
REQ-031 Armed, driving from source A -> pull rst_n low for one clk -> all ports z after that edge. Release rst_n -> driving resumes one clk later.
